sr04_multi_ranger: RTL

Parametrised HC-SR04 ranging engine that drives NUM_CH ultrasonic sensors in strict round-robin, one channel in flight at a time to avoid acoustic crosstalk. Each measurement yields a per-channel distance in cm plus an error flag, and a one-cycle result strobe. The block sits between the sensor I/O pins and the display/UART consumers, and replaces the single-channel fixed-timing controller.

---
 rtl/sr04_pkg.sv | 29 ++
 rtl/sr04_multi_ranger_if.sv | 23 ++
 rtl/sr04_tick_gen.sv | 30 +++
 rtl/sr04_multi_ranger.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr04_pkg.sv
// Shared types and constants for the HC-SR04 ranging engine.
// Holds the FSM state encoding, the us-to-cm scaling constants and the tick divider helper.
package sr04_pkg;

  typedef enum logic [2:0] {
    ST_GAP  = 3'd0,
    ST_TRIG = 3'd1,
    ST_WAIT = 3'd2,
    ST_MEAS = 3'd3,
    ST_DONE = 3'd4
  } sr04_state_e;

  // 1130/65536 ~= 1/58 converts round-trip echo microseconds to centimetres
  localparam int unsigned DIST_SCALE = 1130;
  localparam int unsigned DIST_SHIFT = 16;
  localparam int unsigned US_CNT_W   = 16;

  function automatic int unsigned tick_div(input int unsigned clk_hz);
    int unsigned div;
    div = clk_hz / 1_000_000;
    if (div < 1) begin
      div = 1;
    end else begin
      div = div;
    end
    return div;
  endfunction

endpackage

// File: rtl/sr04_multi_ranger_if.sv
// Result bus of the ranging engine towards display/UART consumers.
// master = ranging engine, slave = consumer.
interface sr04_multi_ranger_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIST_W = 9
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                       dist_valid;
  logic [CH_W-1:0]            dist_ch;
  logic [DIST_W-1:0]          dist_cm;
  logic                       dist_err;
  logic [NUM_CH*DIST_W-1:0]   dist_all;
  logic [NUM_CH-1:0]          err_all;

  modport master (
    output dist_valid, dist_ch, dist_cm, dist_err, dist_all, err_all
  );

  modport slave (
    input dist_valid, dist_ch, dist_cm, dist_err, dist_all, err_all
  );
endinterface

// File: rtl/sr04_tick_gen.sv
// Parametrised 1 us prescaler: one-cycle tick every DIV clocks, first tick DIV clocks after reset.
module sr04_tick_gen #(
  parameter int unsigned DIV = 100
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int unsigned      CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             tick_r;

  // free-running divider with registered tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (cnt_r == LAST) begin
      cnt_r  <= '0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + CNT_W'(1);
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;
endmodule

// File: rtl/sr04_multi_ranger.sv
// Round-robin HC-SR04 ranging engine, one channel in flight at a time.
// Optional `SR04_AVG_EN: per-channel 4-sample moving average of valid distances.
module sr04_multi_ranger
  import sr04_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned TRIG_US         = 10,
  parameter int unsigned GAP_US          = 60000,
  parameter int unsigned WAIT_TIMEOUT_US = 30000,
  parameter int unsigned ECHO_TIMEOUT_US = 25000,
  parameter int unsigned DIST_W          = 9,
  parameter int unsigned MAX_CM          = 400
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   echo,
  output logic [NUM_CH-1:0]   trigger,
  sr04_multi_ranger_if.master res
);
  localparam int unsigned         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned         DIV      = tick_div(CLK_HZ);
  localparam logic [US_CNT_W-1:0] GAP_LAST = US_CNT_W'(GAP_US - 1);
  localparam logic [US_CNT_W-1:0] TRIG_LAST = US_CNT_W'(TRIG_US - 1);
  localparam logic [US_CNT_W-1:0] WAIT_TO  = US_CNT_W'(WAIT_TIMEOUT_US);
  localparam logic [US_CNT_W-1:0] ECHO_TO  = US_CNT_W'(ECHO_TIMEOUT_US);
  localparam logic [CH_W-1:0]     CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [DIST_W-1:0]   MAX_D    = DIST_W'(MAX_CM);
  localparam logic [NUM_CH-1:0]   CH0_HOT  = NUM_CH'(1);

  logic                     tick_s;
  logic [NUM_CH-1:0]        echo_s1_r, echo_s2_r, echo_s3_r;
  logic                     echo_lvl_s, echo_rise_s, meas_ok_s;
  sr04_state_e              state_r;
  logic [CH_W-1:0]          ch_r;
  logic [US_CNT_W-1:0]      us_cnt_r, us_inc_s;
  logic [26:0]              prod_s, scaled_s;
  logic [DIST_W-1:0]        dist_raw_s, result_cm_s;
  logic [NUM_CH-1:0]        trigger_r;
  logic                     valid_r, dist_err_r;
  logic [CH_W-1:0]          dist_ch_r;
  logic [DIST_W-1:0]        dist_cm_r;
  logic [NUM_CH*DIST_W-1:0] dist_all_r;
  logic [NUM_CH-1:0]        err_all_r;

  sr04_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_s)
  );

  // two-stage synchroniser plus a delay stage for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_s1_r <= '0;
      echo_s2_r <= '0;
      echo_s3_r <= '0;
    end else begin
      echo_s1_r <= echo;
      echo_s2_r <= echo_s1_r;
      echo_s3_r <= echo_s2_r;
    end
  end

  assign echo_lvl_s  = echo_s2_r[ch_r];
  assign echo_rise_s = echo_s2_r[ch_r] & ~echo_s3_r[ch_r];
  assign meas_ok_s   = (state_r == ST_MEAS) && !echo_lvl_s;
  assign us_inc_s    = (us_cnt_r == {US_CNT_W{1'b1}}) ? us_cnt_r : us_cnt_r + US_CNT_W'(1);

  // echo time to centimetres, saturated at MAX_CM
  always_comb begin
    prod_s   = 27'(us_cnt_r) * 27'(DIST_SCALE);
    scaled_s = prod_s >> DIST_SHIFT;
    if (scaled_s > 27'(MAX_CM)) begin
      dist_raw_s = MAX_D;
    end else begin
      dist_raw_s = DIST_W'(scaled_s);
    end
  end

`ifdef SR04_AVG_EN
  localparam int unsigned HIST_D = 3;
  localparam int unsigned SUM_W  = DIST_W + 2;

  // the three previous valid samples; the incoming one completes the window of four
  logic [DIST_W-1:0] hist_r [NUM_CH][HIST_D];
  logic [NUM_CH-1:0] primed_r;
  logic [SUM_W-1:0]  sum_s;

  // a fresh channel behaves as if its whole window held the first sample
  always_comb begin
    if (primed_r[ch_r]) begin
      sum_s = SUM_W'(dist_raw_s) + SUM_W'(hist_r[ch_r][0]) +
              SUM_W'(hist_r[ch_r][1]) + SUM_W'(hist_r[ch_r][2]);
    end else begin
      sum_s = {dist_raw_s, 2'b00};
    end
    result_cm_s = DIST_W'(sum_s >> 2);
  end

  // push valid samples only; timeouts leave the history untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed_r <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        for (int j = 0; j < HIST_D; j++) begin
          hist_r[i][j] <= '0;
        end
      end
    end else if (meas_ok_s) begin
      primed_r[ch_r] <= 1'b1;
      if (!primed_r[ch_r]) begin
        for (int j = 0; j < HIST_D; j++) begin
          hist_r[ch_r][j] <= dist_raw_s;
        end
      end else begin
        hist_r[ch_r][2] <= hist_r[ch_r][1];
        hist_r[ch_r][1] <= hist_r[ch_r][0];
        hist_r[ch_r][0] <= dist_raw_s;
      end
    end
  end
`else
  assign result_cm_s = dist_raw_s;
`endif

  // measurement sequencer; results are published on the transition into DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_GAP;
      ch_r       <= '0;
      us_cnt_r   <= '0;
      trigger_r  <= '0;
      valid_r    <= 1'b0;
      dist_ch_r  <= '0;
      dist_cm_r  <= '0;
      dist_err_r <= 1'b0;
      dist_all_r <= '0;
      err_all_r  <= '0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        ST_GAP: begin
          if (!enable) begin
            us_cnt_r <= '0;
          end else if (tick_s) begin
            if (us_cnt_r == GAP_LAST) begin
              state_r   <= ST_TRIG;
              us_cnt_r  <= '0;
              trigger_r <= CH0_HOT << ch_r;
            end else begin
              us_cnt_r <= us_inc_s;
            end
          end
        end
        ST_TRIG: begin
          if (tick_s) begin
            if (us_cnt_r == TRIG_LAST) begin
              state_r   <= ST_WAIT;
              us_cnt_r  <= '0;
              trigger_r <= '0;
            end else begin
              us_cnt_r <= us_inc_s;
            end
          end
        end
        ST_WAIT: begin
          if (echo_rise_s) begin
            state_r  <= ST_MEAS;
            us_cnt_r <= '0;
          end else if (us_cnt_r >= WAIT_TO) begin
            state_r          <= ST_DONE;
            us_cnt_r         <= '0;
            valid_r          <= 1'b1;
            dist_ch_r        <= ch_r;
            dist_cm_r        <= MAX_D;
            dist_err_r       <= 1'b1;
            err_all_r[ch_r]  <= 1'b1;
          end else if (tick_s) begin
            us_cnt_r <= us_inc_s;
          end
        end
        ST_MEAS: begin
          if (meas_ok_s) begin
            state_r                              <= ST_DONE;
            us_cnt_r                             <= '0;
            valid_r                              <= 1'b1;
            dist_ch_r                            <= ch_r;
            dist_cm_r                            <= result_cm_s;
            dist_err_r                           <= 1'b0;
            err_all_r[ch_r]                      <= 1'b0;
            dist_all_r[ch_r*DIST_W +: DIST_W]    <= result_cm_s;
          end else if (us_cnt_r >= ECHO_TO) begin
            state_r          <= ST_DONE;
            us_cnt_r         <= '0;
            valid_r          <= 1'b1;
            dist_ch_r        <= ch_r;
            dist_cm_r        <= MAX_D;
            dist_err_r       <= 1'b1;
            err_all_r[ch_r]  <= 1'b1;
          end else if (tick_s) begin
            us_cnt_r <= us_inc_s;
          end
        end
        ST_DONE: begin
          state_r  <= ST_GAP;
          us_cnt_r <= '0;
          ch_r     <= (ch_r == CH_LAST) ? '0 : ch_r + CH_W'(1);
        end
        default: begin
          state_r   <= ST_GAP;
          us_cnt_r  <= '0;
          trigger_r <= '0;
        end
      endcase
    end
  end

  assign trigger        = trigger_r;
  assign res.dist_valid = valid_r;
  assign res.dist_ch    = dist_ch_r;
  assign res.dist_cm    = dist_cm_r;
  assign res.dist_err   = dist_err_r;
  assign res.dist_all   = dist_all_r;
  assign res.err_all    = err_all_r;
endmodule
